alu_exec_ctrl: RTL and testbench
================================

Name: alu_exec_ctrl

Overview:
- Parametrised successor to the combinational ALU-control decoder. It merges ALUOp/funct decode with a registered execute stage.
- Adds multi-cycle unsigned multiply/divide with HI/LO registers and a valid/ready issue handshake.
- Sits in the EX stage between the main control unit (supplies ALUOp) and the EX/MEM register.
- Stalls issue while a multi-cycle operation is in flight.

Parameters:
- WIDTH, 32, datapath width in bits (≥ 4).
- MUL_CYCLES, WIDTH, iteration count of the shift-add multiplier (≥ 1).
- DIV_CYCLES, WIDTH, iteration count of the restoring divider (≥ 1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operation presented this cycle.
- in_ready  out  1  block can accept an operation this cycle.
- in_aluop  in  3  ALUOp from main control.
- funct  in  6  R-type funct field.
- op_a  in  WIDTH  operand A (rs).
- op_b  in  WIDTH  operand B (rt or extended immediate).
- out_valid  out  1  result/zero valid, one-cycle pulse per accepted operation.
- result  out  WIDTH  registered result.
- zero  out  1  registered (result == 0).
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- busy  out  1  multi-cycle operation in progress (equals ~in_ready).

Behaviour:
- Reset: state IDLE; in_ready=1, busy=0, out_valid=0, result=0, zero=1, hi=0, lo=0, iteration counter=0. Reset mid-MUL/DIV aborts the operation, leaves HI/LO=0, and produces no out_valid.
- Accept: an operation is accepted on a rising edge where in_valid && in_ready. in_aluop, funct, op_a and op_b are sampled only at acceptance.
- Decode for in_aluop=111 (R-type), by funct:
  - 100000 add; 100010 sub; 100100 and; 100101 or; 101010 slt (signed).
  - 011001 multu; 011011 divu; 010000 mfhi; 010010 mflo.
  - 000000 and any other funct: nop.
- Decode for other in_aluop values:
  - 001 add (lw/sw); 000 sub (beq); 101 add (addi); 100 slt (slti); 011 and (andi); 010 or (ori).
  - 110: nop.
- Nop: result=0, zero=1, out_valid still pulses.
- Arithmetic: add/sub wrap modulo 2^WIDTH with no overflow trap. slt gives result 1 if $signed(a) < $signed(b), else 0. mfhi returns hi; mflo returns lo.
- Single-cycle ops: result, zero and out_valid are registered on the accept edge, so out_valid is high in the following cycle for exactly one cycle. in_ready stays 1, allowing back-to-back issue every cycle.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE → MUL on accepted multu; IDLE → DIV on accepted divu. Operands are latched and the counter is cleared. in_ready/busy flip on that edge.
  - MUL: one shift-add iteration per cycle. Exit to DONE after MUL_CYCLES iterations. Counter width is $clog2(max(MUL_CYCLES, DIV_CYCLES)+1).
  - DIV: one restoring iteration per cycle. Exit to DONE after DIV_CYCLES iterations.
  - Transition edge into DONE: write hi/lo and result=lo_new; zero reflects lo_new; out_valid=1 for the DONE cycle.
  - DONE → IDLE unconditionally. in_ready=1 during the DONE cycle, so a new operation can be accepted there.
- multu: {hi,lo} = op_a * op_b, full 2*WIDTH-bit unsigned product.
- divu: lo = quotient, hi = remainder.
- divu by zero: lo = all ones, hi = op_a. Same DIV_CYCLES latency.
- Latency: from the accept edge, out_valid rises after MUL_CYCLES+1 edges for multu and DIV_CYCLES+1 edges for divu.
- mfhi/mflo accepted in the DONE cycle read the new HI/LO values.
- in_valid while busy: ignored and not queued. Upstream must hold the operation; the block does not capture it.
- hi/lo change only on a multu/divu completion or reset.

Test Plan:
- Reset, then add 5+7 (aluop 111, funct 100000) → out_valid pulse 1 cycle later, result=12, zero=0. beq sub 9−9 (aluop 000) → result=0, zero=1.
- slt with op_a=0xFFFFFFFF, op_b=1 → result=1. slti (aluop 100) with op_a=3, op_b=2 → result=0. Add 0xFFFFFFFF+1 → result=0, zero=1 (wrap).
- multu 0xFFFFFFFF×2 → in_ready low for 32 cycles, out_valid 33 edges after accept, hi=1, lo=0xFFFFFFFE, result=lo. mfhi issued in the DONE cycle → result=1.
- divu 100÷7 → lo=14, hi=2. divu 55÷0 → lo=0xFFFFFFFF, hi=55. in_valid held high during busy → exactly one out_valid per accepted operation, none lost or duplicated.
- Assert reset at iteration 10 of a multu → next cycle in_ready=1, hi=lo=0, no out_valid pulse.
- Re-run WIDTH=8, MUL_CYCLES=DIV_CYCLES=8: multu 0xFF×0xFF → hi=0xFE, lo=0x01, latency 9 edges. Unknown funct 111111 → nop, result=0, zero=1.

Source files
------------

// File: rtl/alu_exec_ctrl.sv
// rtl/alu_exec_ctrl.sv - ALUOp/funct decode with registered execute stage and multi-cycle multu/divu
//
// Purpose: decodes ALUOp and funct, runs single-cycle ALU ops directly into a
// registered result, and runs unsigned multiply/divide as a multi-cycle FSM
// that writes the HI/LO registers.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   in_valid/in_ready   issue handshake; accept when both high on a rising edge
//   in_aluop, funct     ALUOp from main control, R-type funct field
//   op_a, op_b          operands, sampled only at acceptance
//   out_valid           one-cycle pulse per accepted operation
//   result, zero        registered result and (result == 0)
//   hi, lo              HI/LO registers written by multu/divu
//   busy                multi-cycle op in flight (~in_ready)
module alu_exec_ctrl #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = WIDTH,
  parameter int DIV_CYCLES = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_aluop,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy
);

  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  // Bits retired per iteration so that WIDTH bits finish within the cycle budget.
  localparam int MK   = (WIDTH + MUL_CYCLES - 1) / MUL_CYCLES;
  localparam int DK   = (WIDTH + DIV_CYCLES - 1) / DIV_CYCLES;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  typedef enum logic [3:0] {
    OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT,
    OP_MULTU, OP_DIVU, OP_MFHI, OP_MFLO
  } op_t;

  state_t             state;
  op_t                op;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   alu_res;

  logic [2*WIDTH-1:0] acc, acc_nxt, mcand, mcand_nxt;
  logic [WIDTH-1:0]   mplier, mplier_nxt;
  logic [WIDTH-1:0]   quo, quo_nxt, rem, rem_nxt, divisor;
  logic [WIDTH:0]     trial;

  assign in_ready = (state == IDLE) || (state == DONE);
  assign busy     = ~in_ready;

  always_comb begin
    op = OP_NOP;
    if (in_aluop == 3'b111) begin
      case (funct)
        6'b100000: op = OP_ADD;
        6'b100010: op = OP_SUB;
        6'b100100: op = OP_AND;
        6'b100101: op = OP_OR;
        6'b101010: op = OP_SLT;
        6'b011001: op = OP_MULTU;
        6'b011011: op = OP_DIVU;
        6'b010000: op = OP_MFHI;
        6'b010010: op = OP_MFLO;
        default:   op = OP_NOP;
      endcase
    end else begin
      case (in_aluop)
        3'b001, 3'b101: op = OP_ADD;
        3'b000:         op = OP_SUB;
        3'b100:         op = OP_SLT;
        3'b011:         op = OP_AND;
        3'b010:         op = OP_OR;
        default:        op = OP_NOP;
      endcase
    end
  end

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_MFHI: alu_res = hi;
      OP_MFLO: alu_res = lo;
      default: alu_res = '0;
    endcase
  end

  // Shift-add step; surplus bit slots just see a zero multiplier.
  always_comb begin
    acc_nxt    = acc;
    mcand_nxt  = mcand;
    mplier_nxt = mplier;
    for (int j = 0; j < MK; j++) begin
      if (mplier_nxt[0]) acc_nxt = acc_nxt + mcand_nxt;
      mcand_nxt  = mcand_nxt << 1;
      mplier_nxt = mplier_nxt >> 1;
    end
  end

  // Restoring step; bit slots beyond WIDTH total are skipped so the
  // quotient is not shifted past its final position. A zero divisor
  // naturally yields all-ones quotient and remainder == dividend.
  always_comb begin
    quo_nxt = quo;
    rem_nxt = rem;
    trial   = '0;
    for (int j = 0; j < DK; j++) begin
      if (int'(cnt) * DK + j < WIDTH) begin
        trial   = {rem_nxt, quo_nxt[WIDTH-1]};
        quo_nxt = quo_nxt << 1;
        if (trial >= {1'b0, divisor}) begin
          rem_nxt    = trial[WIDTH-1:0] - divisor;
          quo_nxt[0] = 1'b1;
        end else begin
          rem_nxt = trial[WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b1;
      hi        <= '0;
      lo        <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      quo       <= '0;
      rem       <= '0;
      divisor   <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (in_valid) begin
            cnt <= '0;
            if (op == OP_MULTU) begin
              state  <= MUL;
              acc    <= '0;
              mcand  <= {{WIDTH{1'b0}}, op_a};
              mplier <= op_b;
            end else if (op == OP_DIVU) begin
              state   <= DIV;
              quo     <= op_a;
              rem     <= '0;
              divisor <= op_b;
            end else begin
              result    <= alu_res;
              zero      <= (alu_res == '0);
              out_valid <= 1'b1;
            end
          end
        end
        MUL: begin
          acc    <= acc_nxt;
          mcand  <= mcand_nxt;
          mplier <= mplier_nxt;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(MUL_CYCLES - 1)) begin
            state     <= DONE;
            hi        <= acc_nxt[2*WIDTH-1:WIDTH];
            lo        <= acc_nxt[WIDTH-1:0];
            result    <= acc_nxt[WIDTH-1:0];
            zero      <= (acc_nxt[WIDTH-1:0] == '0);
            out_valid <= 1'b1;
          end
        end
        DIV: begin
          quo <= quo_nxt;
          rem <= rem_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(DIV_CYCLES - 1)) begin
            state     <= DONE;
            hi        <= rem_nxt;
            lo        <= quo_nxt;
            result    <= quo_nxt;
            zero      <= (quo_nxt == '0);
            out_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// tb/tb_alu_exec_ctrl.sv - bench for alu_exec_ctrl at WIDTH=32 and WIDTH=8
module tb_alu_exec_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [2:0]  aluop;
  logic [5:0]  fn;
  logic [31:0] opa, opb;

  logic        v32, r32, ov32, z32, b32;
  logic [31:0] res32, hi32, lo32;
  logic        v8, r8, ov8, z8, b8;
  logic [7:0]  res8, hi8, lo8;

  int n_pass = 0;
  int n_fail = 0;
  int n_checks = 0;
  int ov_cnt [2];
  int accepted [2];
  logic [31:0] mh [2];
  logic [31:0] ml [2];

  alu_exec_ctrl #(.WIDTH(32), .MUL_CYCLES(32), .DIV_CYCLES(32)) dut32 (
    .clk(clk), .reset(reset), .in_valid(v32), .in_ready(r32),
    .in_aluop(aluop), .funct(fn), .op_a(opa), .op_b(opb),
    .out_valid(ov32), .result(res32), .zero(z32), .hi(hi32), .lo(lo32), .busy(b32)
  );

  alu_exec_ctrl #(.WIDTH(8), .MUL_CYCLES(8), .DIV_CYCLES(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(v8), .in_ready(r8),
    .in_aluop(aluop), .funct(fn), .op_a(opa[7:0]), .op_b(opb[7:0]),
    .out_valid(ov8), .result(res8), .zero(z8), .hi(hi8), .lo(lo8), .busy(b8)
  );

  always @(negedge clk) begin
    if (ov32) ov_cnt[0]++;
    if (ov8)  ov_cnt[1]++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic f_rdy(input bit s8);  return s8 ? r8 : r32;  endfunction
  function automatic logic f_ov(input bit s8);   return s8 ? ov8 : ov32; endfunction
  function automatic logic f_zero(input bit s8); return s8 ? z8 : z32;  endfunction
  function automatic logic [31:0] f_res(input bit s8); return s8 ? {24'b0, res8} : res32; endfunction
  function automatic logic [31:0] f_hi(input bit s8);  return s8 ? {24'b0, hi8} : hi32;   endfunction
  function automatic logic [31:0] f_lo(input bit s8);  return s8 ? {24'b0, lo8} : lo32;   endfunction

  function automatic string op_name(input logic [2:0] aop, input logic [5:0] f);
    if (aop == 3'b111) begin
      case (f)
        6'h20: return "add";
        6'h22: return "sub";
        6'h24: return "and";
        6'h25: return "or";
        6'h2A: return "slt";
        6'h19: return "multu";
        6'h1B: return "divu";
        6'h10: return "mfhi";
        6'h12: return "mflo";
        default: return "nop";
      endcase
    end
    case (aop)
      3'd1, 3'd5: return "add";
      3'd0: return "sub";
      3'd4: return "slt";
      3'd3: return "and";
      3'd2: return "or";
      default: return "nop";
    endcase
  endfunction

  task automatic model(input bit s8, input string nm, input logic [31:0] a_in, input logic [31:0] b_in,
                       output logic [31:0] res);
    logic [31:0] m, a, b;
    logic [63:0] p;
    longint sa, sb;
    int w;
    w = s8 ? 8 : 32;
    m = s8 ? 32'hFF : 32'hFFFF_FFFF;
    a = a_in & m;
    b = b_in & m;
    sa = s8 ? longint'($signed(a[7:0])) : longint'($signed(a));
    sb = s8 ? longint'($signed(b[7:0])) : longint'($signed(b));
    res = 32'h0;
    case (nm)
      "add":  res = (a + b) & m;
      "sub":  res = (a - b) & m;
      "and":  res = a & b;
      "or":   res = a | b;
      "slt":  res = (sa < sb) ? 32'd1 : 32'd0;
      "mfhi": res = mh[s8];
      "mflo": res = ml[s8];
      "multu": begin
        p = 64'(a) * 64'(b);
        ml[s8] = p[31:0] & m;
        mh[s8] = 32'(p >> w) & m;
        res = ml[s8];
      end
      "divu": begin
        if (b == 0) begin
          ml[s8] = m;
          mh[s8] = a;
        end else begin
          ml[s8] = a / b;
          mh[s8] = a % b;
        end
        res = ml[s8];
      end
      default: res = 32'h0;
    endcase
  endtask

  // Called at a negedge with the target DUT ready; returns at the negedge
  // of the out_valid cycle with in_valid dropped.
  task automatic do_op(input bit s8, input logic [2:0] aop, input logic [5:0] f,
                       input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] er;
    string nm;
    bit multi, rdy_seen;
    int edges, lat;
    nm = op_name(aop, f);
    multi = (nm == "multu") || (nm == "divu");
    model(s8, nm, a, b, er);
    aluop = aop; fn = f; opa = a; opb = b;
    if (s8) v8 = 1'b1; else v32 = 1'b1;
    check({tag, " in_ready"}, f_rdy(s8), 1'b1);
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    rdy_seen = 1'b0;
    if (multi) begin
      // keep presenting a different op while busy; it must not be captured
      aluop = 3'b111; fn = 6'h20; opa = $urandom; opb = $urandom;
    end else begin
      v8 = 1'b0; v32 = 1'b0;
    end
    while (!f_ov(s8) && edges < 80) begin
      rdy_seen |= f_rdy(s8);
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    v8 = 1'b0; v32 = 1'b0;
    lat = multi ? (s8 ? 9 : 33) : 1;
    accepted[s8]++;
    check({tag, " latency"}, edges, lat);
    check({tag, " result"}, f_res(s8), er);
    check({tag, " zero"}, f_zero(s8), (er == 0));
    check({tag, " hi"}, f_hi(s8), mh[s8]);
    check({tag, " lo"}, f_lo(s8), ml[s8]);
    if (multi) check({tag, " ready_while_busy"}, rdy_seen, 1'b0);
  endtask

  task automatic rand_ops(input bit s8, input int n);
    logic [2:0] aop;
    logic [5:0] f;
    logic [31:0] a, b;
    logic [5:0] rfuncts [10];
    rfuncts = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h19, 6'h1B, 6'h10, 6'h12, 6'h3F};
    for (int i = 0; i < n; i++) begin
      aop = 3'($urandom_range(0, 7));
      f   = (aop == 3'b111) ? rfuncts[$urandom_range(0, 9)] : 6'($urandom);
      a   = $urandom;
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = 32'h0;
        2: b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      do_op(s8, aop, f, a, b, s8 ? "rand8" : "rand32");
    end
  endtask

  initial begin
    int ov_after;
    reset = 1'b1; v32 = 1'b0; v8 = 1'b0;
    aluop = 3'b0; fn = 6'b0; opa = 32'b0; opb = 32'b0;
    mh = '{32'h0, 32'h0}; ml = '{32'h0, 32'h0};
    ov_cnt = '{0, 0}; accepted = '{0, 0};
    repeat (2) @(negedge clk);
    check("rst ready", r32, 1'b1);
    check("rst busy", b32, 1'b0);
    check("rst out_valid", ov32, 1'b0);
    check("rst result", res32, 32'h0);
    check("rst zero", z32, 1'b1);
    check("rst hi", hi32, 32'h0);
    check("rst lo", lo32, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    do_op(0, 3'b111, 6'h20, 32'd5, 32'd7, "add 5+7");
    do_op(0, 3'b000, 6'h15, 32'd9, 32'd9, "beq 9-9");
    do_op(0, 3'b111, 6'h2A, 32'hFFFF_FFFF, 32'd1, "slt -1<1");
    do_op(0, 3'b100, 6'h00, 32'd3, 32'd2, "slti 3<2");
    do_op(0, 3'b111, 6'h20, 32'hFFFF_FFFF, 32'd1, "add wrap");
    do_op(0, 3'b111, 6'h19, 32'hFFFF_FFFF, 32'd2, "multu");
    do_op(0, 3'b111, 6'h10, 32'd0, 32'd0, "mfhi in DONE");
    do_op(0, 3'b111, 6'h1B, 32'd100, 32'd7, "divu 100/7");
    do_op(0, 3'b111, 6'h12, 32'd0, 32'd0, "mflo in DONE");
    do_op(0, 3'b111, 6'h1B, 32'd55, 32'd0, "divu 55/0");
    do_op(0, 3'b110, 6'h20, 32'd4, 32'd4, "aluop 110 nop");

    // reset in the middle of a multiply
    aluop = 3'b111; fn = 6'h19; opa = 32'h1234_5678; opb = 32'h9ABC_DEF0;
    v32 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v32 = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mh = '{32'h0, 32'h0}; ml = '{32'h0, 32'h0};
    check("midreset ready", r32, 1'b1);
    check("midreset hi", hi32, 32'h0);
    check("midreset lo", lo32, 32'h0);
    check("midreset out_valid", ov32, 1'b0);
    ov_after = 0;
    repeat (40) begin
      @(negedge clk);
      if (ov32) ov_after++;
    end
    check("midreset no pulse", ov_after, 0);

    rand_ops(0, 40);

    do_op(1, 3'b111, 6'h19, 32'hFF, 32'hFF, "w8 multu");
    do_op(1, 3'b111, 6'h3F, 32'h12, 32'h34, "w8 unknown funct");
    do_op(1, 3'b111, 6'h1B, 32'hC8, 32'h00, "w8 divu by 0");
    do_op(1, 3'b111, 6'h2A, 32'h80, 32'h7F, "w8 slt");
    rand_ops(1, 40);

    @(negedge clk);
    check("pulses32", ov_cnt[0], accepted[0]);
    check("pulses8", ov_cnt[1], accepted[1]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
